// File: rtl/tetris_pkg.sv
// Shared Tetris board geometry, VGA timing constants and scheduler state type.
package tetris_pkg;

    localparam int BOARD_ROWS   = 20;
    localparam int BOARD_COLS   = 12;
    localparam int BOARD_BITS   = BOARD_ROWS * BOARD_COLS;

    localparam int H_TOTAL      = 800;
    localparam int V_ACTIVE_END = 514;

    typedef enum logic {
        IDLE    = 1'b0,
        PENDING = 1'b1
    } sched_state_t;

endpackage

// File: rtl/frame_tick_div.sv
// Frame counter: emits a frame_tick on every vblank event and a game_tick
// on the vblank where the counter wraps after FRAME_DIV frames.
module frame_tick_div #(
    parameter int FRAME_DIV = 30
) (
    input  logic clk,
    input  logic rst_n,
    input  logic vblank,
    output logic frame_tick,
    output logic game_tick
);

    localparam int CW = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(FRAME_DIV - 1);

    logic [CW-1:0] frame_cnt;

    // Advance the frame counter on each vblank and register the tick pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt  <= '0;
            frame_tick <= 1'b0;
            game_tick  <= 1'b0;
        end else begin
            frame_tick <= vblank;
            game_tick  <= 1'b0;
            if (vblank) begin
                if (frame_cnt == LAST) begin
                    frame_cnt <= '0;
                    game_tick <= 1'b1;
                end else begin
                    frame_cnt <= frame_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/board_frame_scheduler.sv
// Display-board owner: buffers one game-logic update in a shadow register and
// commits it (or a pending clear) only at the start of vertical blanking.
// Optional statistics counters are enabled with BOARD_SCHED_STATS_EN.
module board_frame_scheduler
    import tetris_pkg::BOARD_BITS, tetris_pkg::sched_state_t,
           tetris_pkg::IDLE, tetris_pkg::PENDING;
#(
    parameter int H_TOTAL      = tetris_pkg::H_TOTAL,
    parameter int V_ACTIVE_END = tetris_pkg::V_ACTIVE_END,
    parameter int FRAME_DIV    = 30
) (
    input  logic                  clk25MHz,
    input  logic                  rst_n,
    input  logic [9:0]            counter_x,
    input  logic [9:0]            counter_y,
    input  logic                  upd_valid,
    input  logic [BOARD_BITS-1:0] upd_data,
    output logic                  upd_ready,
    input  logic                  clear_req,
    output logic [BOARD_BITS-1:0] board,
    output logic                  frame_tick,
    output logic                  game_tick,
    output logic                  commit_done,
    output logic                  upd_dropped
`ifdef BOARD_SCHED_STATS_EN
    ,
    output logic [15:0]           commit_cnt,
    output logic [15:0]           stall_cnt
`endif
);

    sched_state_t          state;
    logic [BOARD_BITS-1:0] shadow;
    logic                  clear_flag;
    logic                  vblank;
    logic                  clear_now;
    logic                  commit_now;

    // Vblank event is the last pixel of the last active line.
    assign vblank     = (counter_x == 10'(H_TOTAL - 1)) && (counter_y == 10'(V_ACTIVE_END));
    // A clear requested on the vblank cycle itself still applies at this vblank.
    assign clear_now  = vblank && (clear_flag || clear_req);
    assign commit_now = vblank && (clear_now || (state == PENDING));

    // Handshake, shadow capture and vblank-aligned commit/clear of the board.
    always_ff @(posedge clk25MHz or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            upd_ready   <= 1'b1;
            shadow      <= '0;
            board       <= '0;
            clear_flag  <= 1'b0;
            commit_done <= 1'b0;
            upd_dropped <= 1'b0;
        end else begin
            commit_done <= commit_now;
            upd_dropped <= 1'b0;
            if (clear_req) begin
                clear_flag <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (clear_now) begin
                        board      <= '0;
                        clear_flag <= 1'b0;
                    end
                    if (upd_valid) begin
                        shadow    <= upd_data;
                        state     <= PENDING;
                        upd_ready <= 1'b0;
                    end
                end
                PENDING: begin
                    if (clear_now) begin
                        board       <= '0;
                        shadow      <= '0;
                        clear_flag  <= 1'b0;
                        upd_dropped <= 1'b1;
                        state       <= IDLE;
                        upd_ready   <= 1'b1;
                    end else if (vblank) begin
                        board     <= shadow;
                        state     <= IDLE;
                        upd_ready <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    upd_ready <= 1'b1;
                end
            endcase
        end
    end

    frame_tick_div #(
        .FRAME_DIV (FRAME_DIV)
    ) u_frame_tick_div (
        .clk        (clk25MHz),
        .rst_n      (rst_n),
        .vblank     (vblank),
        .frame_tick (frame_tick),
        .game_tick  (game_tick)
    );

`ifdef BOARD_SCHED_STATS_EN
    // Commit counter wraps; stall counter saturates at all ones.
    always_ff @(posedge clk25MHz or negedge rst_n) begin
        if (!rst_n) begin
            commit_cnt <= '0;
            stall_cnt  <= '0;
        end else begin
            if (commit_now) begin
                commit_cnt <= commit_cnt + 16'd1;
            end
            if (upd_valid && !upd_ready && (stall_cnt != 16'hFFFF)) begin
                stall_cnt <= stall_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_board_frame_scheduler.sv
// Directed self-checking bench for board_frame_scheduler (FRAME_DIV = 3).
module tb_board_frame_scheduler;

    localparam int BITS = 240;

    logic            clk25MHz;
    logic            rst_n;
    logic [9:0]      counter_x;
    logic [9:0]      counter_y;
    logic            upd_valid;
    logic [BITS-1:0] upd_data;
    logic            upd_ready;
    logic            clear_req;
    logic [BITS-1:0] board;
    logic            frame_tick;
    logic            game_tick;
    logic            commit_done;
    logic            upd_dropped;
`ifdef BOARD_SCHED_STATS_EN
    logic [15:0]     commit_cnt;
    logic [15:0]     stall_cnt;
`endif

    int total;
    int bad;

    logic [BITS-1:0] tri_pat;
    logic [BITS-1:0] pat_a;
    logic [BITS-1:0] pat_b;

    board_frame_scheduler #(
        .FRAME_DIV (3)
    ) dut (
        .clk25MHz    (clk25MHz),
        .rst_n       (rst_n),
        .counter_x   (counter_x),
        .counter_y   (counter_y),
        .upd_valid   (upd_valid),
        .upd_data    (upd_data),
        .upd_ready   (upd_ready),
        .clear_req   (clear_req),
        .board       (board),
        .frame_tick  (frame_tick),
        .game_tick   (game_tick),
        .commit_done (commit_done),
        .upd_dropped (upd_dropped)
`ifdef BOARD_SCHED_STATS_EN
        ,
        .commit_cnt  (commit_cnt),
        .stall_cnt   (stall_cnt)
`endif
    );

    // 25 MHz pixel clock
    initial begin
        clk25MHz = 1'b0;
        forever #20 clk25MHz = ~clk25MHz;
    end

    // Advance one clock; outputs are then sampled 1 ns after the edge.
    task automatic step();
        @(posedge clk25MHz);
        #1;
    endtask

    task automatic set_pos(input int x, input int y);
        counter_x = 10'(x);
        counter_y = 10'(y);
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        upd_valid = 1'b0;
        clear_req = 1'b0;
        upd_data  = '0;
        set_pos(0, 0);
        step();
        rst_n = 1'b1;
        step();
    endtask

    // One cycle with the counters at the vblank position.
    task automatic vblank_cycle();
        set_pos(799, 514);
        step();
        set_pos(0, 0);
    endtask

    task automatic test_reset();
        rst_n     = 1'b1;
        upd_valid = 1'b0;
        clear_req = 1'b0;
        upd_data  = '0;
        set_pos(0, 0);
        #3;
        rst_n = 1'b0;
        #2;
        total++;
        if (board !== '0) begin bad++; $display("FAIL reset_board got=%h exp=0", board); end
        total++;
        if (upd_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", upd_ready); end
        total++;
        if ({frame_tick, game_tick, commit_done, upd_dropped} !== 4'b0000) begin
            bad++;
            $display("FAIL reset_pulses got=%b exp=0000", {frame_tick, game_tick, commit_done, upd_dropped});
        end
`ifdef BOARD_SCHED_STATS_EN
        total++;
        if ({commit_cnt, stall_cnt} !== 32'd0) begin bad++; $display("FAIL reset_stats got=%h exp=0", {commit_cnt, stall_cnt}); end
`endif
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_quiet_update();
        do_reset();
        set_pos(100, 200);
        upd_valid = 1'b1;
        upd_data  = tri_pat;
        step();
        upd_valid = 1'b0;
        upd_data  = ~tri_pat;
        total++;
        if (upd_ready !== 1'b0) begin bad++; $display("FAIL quiet_ready_low got=%b exp=0", upd_ready); end
        set_pos(799, 200);
        step();
        set_pos(100, 514);
        step();
        set_pos(799, 513);
        step();
        total++;
        if (board !== '0 || commit_done !== 1'b0) begin
            bad++;
            $display("FAIL quiet_before_v board=%h commit=%b exp board=0 commit=0", board, commit_done);
        end
        vblank_cycle();
        total++;
        if (board !== tri_pat) begin bad++; $display("FAIL quiet_commit_board got=%h exp=%h", board, tri_pat); end
        total++;
        if (commit_done !== 1'b1 || frame_tick !== 1'b1 || upd_ready !== 1'b1) begin
            bad++;
            $display("FAIL quiet_commit_flags commit=%b tick=%b ready=%b exp 1 1 1", commit_done, frame_tick, upd_ready);
        end
        step();
        total++;
        if (commit_done !== 1'b0 || frame_tick !== 1'b0) begin
            bad++;
            $display("FAIL quiet_pulse_width commit=%b tick=%b exp 0 0", commit_done, frame_tick);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        set_pos(10, 10);
        upd_valid = 1'b1;
        upd_data  = pat_a;
        step();
        upd_data = pat_b;
        repeat (5) step();
        total++;
        if (upd_ready !== 1'b0 || board !== '0) begin
            bad++;
            $display("FAIL b2b_held ready=%b board=%h exp ready=0 board=0", upd_ready, board);
        end
        vblank_cycle();
        total++;
        if (board !== pat_a || upd_ready !== 1'b1) begin
            bad++;
            $display("FAIL b2b_first_commit board=%h ready=%b exp board=%h ready=1", board, upd_ready, pat_a);
        end
        step();
        upd_valid = 1'b0;
        total++;
        if (upd_ready !== 1'b0 || board !== pat_a) begin
            bad++;
            $display("FAIL b2b_second_accept ready=%b board=%h exp ready=0 board=%h", upd_ready, board, pat_a);
        end
`ifdef BOARD_SCHED_STATS_EN
        total++;
        if (stall_cnt !== 16'd6) begin bad++; $display("FAIL b2b_stall_cnt got=%0d exp=6", stall_cnt); end
`endif
        step();
        vblank_cycle();
        total++;
        if (board !== pat_b || commit_done !== 1'b1) begin
            bad++;
            $display("FAIL b2b_second_commit board=%h commit=%b exp board=%h commit=1", board, commit_done, pat_b);
        end
`ifdef BOARD_SCHED_STATS_EN
        total++;
        if (commit_cnt !== 16'd2) begin bad++; $display("FAIL b2b_commit_cnt got=%0d exp=2", commit_cnt); end
`endif
    endtask

    task automatic test_clear_priority();
        do_reset();
        upd_valid = 1'b1;
        upd_data  = pat_a;
        step();
        upd_valid = 1'b0;
        vblank_cycle();
        total++;
        if (board !== pat_a) begin bad++; $display("FAIL clr_setup got=%h exp=%h", board, pat_a); end
        upd_valid = 1'b1;
        upd_data  = pat_b;
        step();
        upd_valid = 1'b0;
        clear_req = 1'b1;
        step();
        clear_req = 1'b0;
        step();
        total++;
        if (board !== pat_a) begin bad++; $display("FAIL clr_not_early got=%h exp=%h", board, pat_a); end
        vblank_cycle();
        total++;
        if (board !== '0) begin bad++; $display("FAIL clr_board got=%h exp=0", board); end
        total++;
        if (upd_dropped !== 1'b1 || commit_done !== 1'b1 || upd_ready !== 1'b1) begin
            bad++;
            $display("FAIL clr_flags dropped=%b commit=%b ready=%b exp 1 1 1", upd_dropped, commit_done, upd_ready);
        end
        step();
        vblank_cycle();
        total++;
        if (board !== '0 || commit_done !== 1'b0 || upd_dropped !== 1'b0) begin
            bad++;
            $display("FAIL clr_flag_cleared board=%h commit=%b dropped=%b exp 0 0 0", board, commit_done, upd_dropped);
        end
        // Clear raised on the vblank cycle itself, with no pending update.
        upd_valid = 1'b1;
        upd_data  = pat_b;
        step();
        upd_valid = 1'b0;
        vblank_cycle();
        step();
        clear_req = 1'b1;
        vblank_cycle();
        clear_req = 1'b0;
        total++;
        if (board !== '0 || commit_done !== 1'b1 || upd_dropped !== 1'b0) begin
            bad++;
            $display("FAIL clr_same_cycle board=%h commit=%b dropped=%b exp 0 1 0", board, commit_done, upd_dropped);
        end
    endtask

    task automatic test_accept_on_v();
        do_reset();
        upd_valid = 1'b1;
        upd_data  = pat_a;
        vblank_cycle();
        upd_valid = 1'b0;
        total++;
        if (board !== '0 || commit_done !== 1'b0 || upd_ready !== 1'b0) begin
            bad++;
            $display("FAIL accv_same_frame board=%h commit=%b ready=%b exp 0 0 0", board, commit_done, upd_ready);
        end
        step();
        vblank_cycle();
        total++;
        if (board !== pat_a || commit_done !== 1'b1) begin
            bad++;
            $display("FAIL accv_next_frame board=%h commit=%b exp board=%h commit=1", board, commit_done, pat_a);
        end
    endtask

    task automatic test_ticks();
        int ft;
        int gt;
        logic [7:0] gt_frames;
        do_reset();
        ft = 0;
        gt = 0;
        gt_frames = '0;
        for (int f = 1; f <= 7; f++) begin
            vblank_cycle();
            if (frame_tick) ft++;
            if (game_tick) begin gt++; gt_frames[f] = 1'b1; end
            step();
            if (frame_tick) ft++;
            if (game_tick) gt++;
        end
        total++;
        if (ft != 7) begin bad++; $display("FAIL ticks_frame got=%0d exp=7", ft); end
        total++;
        if (gt != 2) begin bad++; $display("FAIL ticks_game got=%0d exp=2", gt); end
        total++;
        if (gt_frames !== 8'b0100_1000) begin bad++; $display("FAIL ticks_game_frames got=%b exp=01001000", gt_frames); end
    endtask

    task automatic test_mid_reset();
        do_reset();
        upd_valid = 1'b1;
        upd_data  = pat_a;
        step();
        upd_valid = 1'b0;
        vblank_cycle();
        upd_valid = 1'b1;
        upd_data  = pat_b;
        step();
        upd_valid = 1'b0;
        #5;
        rst_n = 1'b0;
        #2;
        total++;
        if (upd_ready !== 1'b1 || board !== '0) begin
            bad++;
            $display("FAIL mrst_immediate ready=%b board=%h exp ready=1 board=0", upd_ready, board);
        end
        step();
        rst_n = 1'b1;
        step();
        vblank_cycle();
        total++;
        if (board !== '0 || commit_done !== 1'b0 || upd_dropped !== 1'b0) begin
            bad++;
            $display("FAIL mrst_no_commit board=%h commit=%b dropped=%b exp 0 0 0", board, commit_done, upd_dropped);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        tri_pat = '0;
        for (int r = 0; r < 20; r++) begin
            for (int c = 0; c < 12; c++) begin
                if (c <= r) tri_pat[239 - (r * 12 + c)] = 1'b1;
            end
        end
        pat_a = {8{30'h2AAA_5555}};
        pat_b = {16{15'h1234}};
        test_reset();
        test_quiet_update();
        test_back_to_back();
        test_clear_priority();
        test_accept_on_v();
        test_ticks();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
